tc_bank: RTL and testbench
==========================

// Module: tc_bank
// PURPOSE
//  Parametrised timer/counter bank; successor to the fixed 4-timer + 4-counter peripheral.
//  Sits in the execute stage beside accumulatorMUX; driven by the ppReg2 decoded strobes.
//  Adds: N channels, a shared tick prescaler, retentive/off-delay timers,
//  wrap counters, sticky overflow/underflow flags and a registered read path.
// PARAMETERS
//  N_TIMERS    4     timer channels, addresses 0..N_TIMERS-1
//  N_COUNTERS  4     counter channels, addresses N_TIMERS..N_TIMERS+N_COUNTERS-1
//  ACC_W       8     accumulator/preset width; must be >= 8
//  TICK_DIV    1000  clk cycles per timer tick; must be >= 1
//  CH_W        clog2(N_TIMERS+N_COUNTERS)  channel select width (derived)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  ch_sel     in   CH_W   target channel for every command this cycle
//  cfg_we     in   1      write enable bit and type of ch_sel
//  cfg_en     in   1      rung enable value
//  cfg_type   in   2      mode (see BEHAVIOUR)
//  rst_we     in   1      clear acc and flags of ch_sel
//  preset_we  in   1      write wdata into the preset of ch_sel
//  wdata      in   ACC_W  preset data (accumulator)
//  rd_acc     in   1      read request: acc of ch_sel
//  rd_stat    in   1      read request: status of ch_sel
//  rdata      out  ACC_W  read data, registered
//  rvalid     out  1      one-cycle pulse, rdata valid
// BEHAVIOUR
//  Reset: acc=0, preset=0, en=0, type=00, all flags=0, prescaler=0, rdata=0, rvalid=0.
//  Commands with ch_sel >= N_TIMERS+N_COUNTERS are ignored. Read of such a channel returns 0 with rvalid.
//  Commands take effect at the clk edge. New preset/en/type is visible to the comparison from the next cycle.
//  tick: one-cycle pulse every TICK_DIV clocks from the free-running prescaler (TICK_DIV=1 means every cycle).
//  Timer types: 00 TON, 01 TOF, 10 RTO, 11 reserved (acc holds, dn=tt=0).
//   TON: en=1 -> acc+1 per tick, saturating at preset; dn=(acc>=preset); en=0 -> acc=0, dn=0.
//   TOF: en=1 -> dn=1, acc=0; en=0 -> acc+1 per tick until acc==preset, then dn=0.
//   RTO: as TON, but en=0 holds acc and dn; only rst_we clears them.
//   tt=1 while acc is advancing this mode (TON/RTO: en&~dn; TOF: ~en&dn).
//  Counter types: 00 CTU, 01 CTD, 10 CTU-wrap, 11 reserved (acc holds).
//   A count event is a rising edge of en, detected with a registered previous-en; cfg_we en 0->1 is an edge.
//   CTU: acc+1, saturating at 2^ACC_W-1. An event at max sets sticky ov. dn=(acc>=preset).
//   CTD: acc-1, saturating at 0. An event at 0 sets sticky un. dn=(acc<=preset).
//   CTU-wrap: when acc reaches preset, the next event sets acc=0 and pulses dn for 1 cycle.
//   cu=en&(type up), cd=en&(type CTD).
//  Preset lowered below acc: TON/RTO dn=1 next cycle and acc holds. CTU-wrap wraps on the next event.
//  Priority within a cycle: rst_we > cfg_we/preset_we > tick/count event.
//   rst_we with a simultaneous count edge: acc=0, event dropped.
//  cfg_we that changes type clears acc and flags. cfg_we with an unchanged type only updates en.
//  Read: rd_acc or rd_stat -> rdata/rvalid one cycle later. If both are asserted, rd_acc wins.
//   The read returns the pre-edge value, so a same-cycle command is not reflected.
//   Status: bit0 dn, bit1 tt, bit2 cu, bit3 cd, bit4 ov|un, others 0. Counters report tt=0.
//  Reset asserted mid-timing aborts immediately. Timing restarts from acc=0 after deassertion.
// STRUCTURE
//  Shared package: tc_pkg.
//   - type encodings (TON/TOF/RTO, CTU/CTD/CTUW)
//   - status bit positions
//   - CH_W function
//  One sub-module: tc_channel (param IS_TIMER, ACC_W), instantiated N_TIMERS+N_COUNTERS times via generate.
//  Prescaler, address decode and read mux live in tc_bank.
// TESTING
//  TICK_DIV=4, ch0 TON preset 3, en=1 -> dn rises 12 clks (3 ticks) after en. en=0 -> acc=0, dn=0 next clk.
//  ch1 RTO preset 5: en on 2 ticks, off 10 ticks, on 3 ticks -> acc sequence 2,2,...,5, then dn=1.
//   rst_we -> acc=0, dn=0.
//  ch4 CTU preset 2: 3 en pulses -> acc=3, dn=1.
//   At acc=255 one more pulse -> acc=255, status bit4=1.
//  ch5 CTD preset 0, acc=0: pulse -> un=1, acc=0. ch6 CTU-wrap preset 2: 4 pulses -> acc=0,1,2,0,1, dn pulse once.
//  Same cycle rst_we and count edge on ch4 -> acc=0. rd_acc+rd_stat together -> acc returned, rvalid 1 cycle.
//  reset pulse mid-count on all channels -> every status=0x00 and every acc=0 on readback.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared encodings for the timer/counter bank: channel modes, status bit
// positions and the select-width helper.
package tc_pkg;

  typedef enum logic [1:0] {
    T_TON  = 2'b00,
    T_TOF  = 2'b01,
    T_RTO  = 2'b10,
    T_TRSV = 2'b11
  } timer_type_t;

  typedef enum logic [1:0] {
    C_CTU  = 2'b00,
    C_CTD  = 2'b01,
    C_CTUW = 2'b10,
    C_CRSV = 2'b11
  } counter_type_t;

  localparam int ST_W    = 5;
  localparam int ST_DN   = 0;
  localparam int ST_TT   = 1;
  localparam int ST_CU   = 2;
  localparam int ST_CD   = 3;
  localparam int ST_OVUN = 4;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer or counter channel. IS_TIMER selects the TON/TOF/RTO modes,
// otherwise the channel runs CTU/CTD/CTU-wrap.
// 'flag' is the off-delay running bit for TOF and the registered done bit
// for counters (a one-cycle pulse in wrap mode).
module tc_channel import tc_pkg::*; #(
  parameter bit IS_TIMER = 1'b1,
  parameter int ACC_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_type,
  input  logic             rst_we,
  input  logic             preset_we,
  input  logic [ACC_W-1:0] wdata,
  output logic [ACC_W-1:0] acc,
  output logic [ST_W-1:0]  status
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [ACC_W-1:0] preset, acc_n, preset_n;
  logic [1:0]       typ, typ_n;
  logic             en, en_n, en_prev, flag, flag_n, ovun, ovun_n;
  logic             cnt_evt, dn, tt;
  timer_type_t      ttyp;
  counter_type_t    ctyp;

  assign ttyp    = timer_type_t'(typ);
  assign ctyp    = counter_type_t'(typ);
  assign cnt_evt = en && !en_prev;

  // Next-state: mode behaviour first, then config writes, then rst_we on top.
  always_comb begin
    acc_n    = acc;
    preset_n = preset;
    en_n     = en;
    typ_n    = typ;
    flag_n   = flag;
    ovun_n   = ovun;
    if (IS_TIMER) begin
      case (ttyp)
        T_TON: begin
          if (!en) acc_n = '0;
          else if (tick && (acc < preset)) acc_n = acc + 1'b1;
        end
        T_TOF: begin
          if (en) begin
            acc_n  = '0;
            flag_n = 1'b1;
          end else if (flag) begin
            if (acc >= preset) flag_n = 1'b0;
            else if (tick) acc_n = acc + 1'b1;
          end
        end
        T_RTO: begin
          if (en && tick && (acc < preset)) acc_n = acc + 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (ctyp)
        C_CTU: begin
          if (cnt_evt) begin
            if (acc == ACC_MAX) ovun_n = 1'b1;
            else acc_n = acc + 1'b1;
            flag_n = (acc_n >= preset);
          end
        end
        C_CTD: begin
          if (cnt_evt) begin
            if (acc == '0) ovun_n = 1'b1;
            else acc_n = acc - 1'b1;
            flag_n = (acc_n <= preset);
          end
        end
        C_CTUW: begin
          flag_n = 1'b0;
          if (cnt_evt) begin
            if (acc >= preset) begin
              acc_n  = '0;
              flag_n = 1'b1;
            end else begin
              acc_n = acc + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (preset_we) begin
      preset_n = wdata;
      // Counter done tracks a preset rewrite against the current count.
      if (!IS_TIMER && (ctyp == C_CTU)) flag_n = (acc_n >= wdata);
      if (!IS_TIMER && (ctyp == C_CTD)) flag_n = (acc_n <= wdata);
    end
    if (cfg_we) begin
      en_n = cfg_en;
      if (cfg_type != typ) begin
        typ_n  = cfg_type;
        acc_n  = '0;
        flag_n = 1'b0;
        ovun_n = 1'b0;
      end
    end
    if (rst_we) begin
      acc_n  = '0;
      flag_n = 1'b0;
      ovun_n = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      preset  <= '0;
      typ     <= 2'b00;
      en      <= 1'b0;
      en_prev <= 1'b0;
      flag    <= 1'b0;
      ovun    <= 1'b0;
    end else begin
      acc     <= acc_n;
      preset  <= preset_n;
      typ     <= typ_n;
      en      <= en_n;
      en_prev <= en;
      flag    <= flag_n;
      ovun    <= ovun_n;
    end
  end

  // Done / timing decode from the registered state.
  always_comb begin
    dn = 1'b0;
    tt = 1'b0;
    if (IS_TIMER) begin
      case (ttyp)
        T_TON: begin
          dn = en && (acc >= preset);
          tt = en && !dn;
        end
        T_TOF: begin
          dn = en || flag;
          tt = !en && flag;
        end
        T_RTO: begin
          dn = (acc >= preset);
          tt = en && !dn;
        end
        default: ;
      endcase
    end else if (ctyp != C_CRSV) begin
      dn = flag;
    end
  end

  // Status word assembly.
  always_comb begin
    status          = '0;
    status[ST_DN]   = dn;
    status[ST_TT]   = tt;
    status[ST_CU]   = !IS_TIMER && en && ((ctyp == C_CTU) || (ctyp == C_CTUW));
    status[ST_CD]   = !IS_TIMER && en && (ctyp == C_CTD);
    status[ST_OVUN] = ovun;
  end

endmodule

// File: rtl/tc_bank.sv
// Timer/counter bank: shared tick prescaler, channel address decode and a
// registered read port. Channels 0..N_TIMERS-1 are timers, the rest counters.
module tc_bank import tc_pkg::*; #(
  parameter int   N_TIMERS   = 4,
  parameter int   N_COUNTERS = 4,
  parameter int   ACC_W      = 8,
  parameter int   TICK_DIV   = 1000,
  localparam int  CH_W       = width_for(N_TIMERS + N_COUNTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             cfg_we,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_type,
  input  logic             rst_we,
  input  logic             preset_we,
  input  logic [ACC_W-1:0] wdata,
  input  logic             rd_acc,
  input  logic             rd_stat,
  output logic [ACC_W-1:0] rdata,
  output logic             rvalid
);

  localparam int N_CH = N_TIMERS + N_COUNTERS;
  localparam int PW   = width_for(TICK_DIV);

  logic [PW-1:0]    presc;
  logic             tick, sel_ok;
  logic [ACC_W-1:0] acc_arr  [N_CH];
  logic [ST_W-1:0]  stat_arr [N_CH];

  assign tick   = (presc == '0);
  assign sel_ok = ({1'b0, ch_sel} < (CH_W + 1)'(N_CH));

  // Free-running down-counter; tick fires at terminal count zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else if (presc == '0) presc <= PW'(TICK_DIV - 1);
    else presc <= presc - 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = sel_ok && (ch_sel == CH_W'(g));

    tc_channel #(
      .IS_TIMER (g < N_TIMERS),
      .ACC_W    (ACC_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .cfg_we    (cfg_we && hit),
      .cfg_en    (cfg_en),
      .cfg_type  (cfg_type),
      .rst_we    (rst_we && hit),
      .preset_we (preset_we && hit),
      .wdata     (wdata),
      .acc       (acc_arr[g]),
      .status    (stat_arr[g])
    );
  end

  // Registered read: captures pre-edge channel state, acc wins over status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc || rd_stat;
      if (rd_acc || rd_stat) begin
        if (!sel_ok) rdata <= '0;
        else if (rd_acc) rdata <= acc_arr[ch_sel];
        else rdata <= ACC_W'(stat_arr[ch_sel]);
      end
    end
  end

endmodule

// File: tb/tb_tc_bank.sv
// Directed bench for tc_bank with TICK_DIV=4, four timers and three counters
// (channel 7 is therefore an unmapped address).
module tb_tc_bank;

  localparam int ACC_W = 8;
  localparam logic [1:0] TON = 2'b00, TOF = 2'b01, RTO = 2'b10;
  localparam logic [1:0] CTU = 2'b00, CTD = 2'b01, CTUW = 2'b10;
  localparam int K_ACC = 0, K_STAT = 1, K_BOTH = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       ch_sel;
  logic             cfg_we, cfg_en, rst_we, preset_we, rd_acc, rd_stat;
  logic [1:0]       cfg_type;
  logic [ACC_W-1:0] wdata;
  logic [ACC_W-1:0] rdata;
  logic             rvalid;

  int checks;
  int failures;
  int ec;

  tc_bank #(
    .N_TIMERS   (4),
    .N_COUNTERS (3),
    .ACC_W      (ACC_W),
    .TICK_DIV   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_sel    (ch_sel),
    .cfg_we    (cfg_we),
    .cfg_en    (cfg_en),
    .cfg_type  (cfg_type),
    .rst_we    (rst_we),
    .preset_we (preset_we),
    .wdata     (wdata),
    .rd_acc    (rd_acc),
    .rd_stat   (rd_stat),
    .rdata     (rdata),
    .rvalid    (rvalid)
  );

  always #5 clk = ~clk;

  // Edge index since reset release: the first posedge after release is edge 0,
  // which is also the first prescaler tick; ticks follow every 4 edges.
  always @(posedge clk or posedge reset) begin
    if (reset) ec <= 0;
    else ec <= ec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Position so that the next driven command lands on edge k.
  task automatic to_edge(input int k);
    while (ec < k) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input logic en, input logic [1:0] typ);
    ch_sel = 3'(ch); cfg_we = 1'b1; cfg_en = en; cfg_type = typ;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int ch, input logic [7:0] pre, input logic en, input logic [1:0] typ);
    ch_sel = 3'(ch); cfg_we = 1'b1; cfg_en = en; cfg_type = typ;
    preset_we = 1'b1; wdata = pre;
    @(negedge clk);
    cfg_we = 1'b0; preset_we = 1'b0;
  endtask

  task automatic rstc(input int ch);
    ch_sel = 3'(ch); rst_we = 1'b1;
    @(negedge clk);
    rst_we = 1'b0;
  endtask

  task automatic pulse(input int ch, input logic [1:0] typ);
    cfg(ch, 1'b1, typ);
    cfg(ch, 1'b0, typ);
  endtask

  task automatic rd(input int ch, input int kind, input logic [7:0] exp, input string tag);
    ch_sel = 3'(ch); rd_acc = (kind != K_STAT); rd_stat = (kind != K_ACC);
    @(negedge clk);
    rd_acc = 1'b0; rd_stat = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk(tag, 32'(rdata), 32'(exp));
  endtask

  logic [7:0] wrap_acc [4];
  logic [7:0] wrap_st  [4];

  initial begin
    checks = 0; failures = 0;
    ch_sel = '0; cfg_we = 0; cfg_en = 0; cfg_type = '0; rst_we = 0;
    preset_we = 0; wdata = '0; rd_acc = 0; rd_stat = 0;
    wrap_acc = '{8'd1, 8'd2, 8'd0, 8'd1};
    wrap_st  = '{8'h00, 8'h00, 8'h01, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;

    // TON, preset 3: en at tick edge 0, ticks 4/8/12 reach the preset.
    to_edge(0);  setup(0, 8'd3, 1'b1, TON);
    to_edge(12); rd(0, K_STAT, 8'h02, "ton_timing_e11");
    rd(0, K_STAT, 8'h01, "ton_done_e12");
    rd(0, K_ACC, 8'd3, "ton_acc_sat");
    cfg(0, 1'b0, TON);
    rd(0, K_STAT, 8'h00, "ton_off_stat");
    rd(0, K_ACC, 8'd0, "ton_off_acc");

    // RTO, preset 5: on 2 ticks, off 10 ticks, on 3 ticks.
    to_edge(20); setup(1, 8'd5, 1'b1, RTO);
    to_edge(29); cfg(1, 1'b0, RTO);
    to_edge(70); rd(1, K_ACC, 8'd2, "rto_hold_acc");
    rd(1, K_STAT, 8'h00, "rto_hold_stat");
    to_edge(72); cfg(1, 1'b1, RTO);
    to_edge(84); rd(1, K_ACC, 8'd4, "rto_acc4");
    rd(1, K_ACC, 8'd5, "rto_acc5");
    rd(1, K_STAT, 8'h01, "rto_done");
    cfg(1, 1'b0, RTO);
    rstc(1);
    rd(1, K_ACC, 8'd0, "rto_rst_acc");
    rd(1, K_STAT, 8'h00, "rto_rst_stat");

    // CTU, preset 2: three events, then run up to saturation.
    setup(4, 8'd2, 1'b0, CTU);
    repeat (3) pulse(4, CTU);
    rd(4, K_ACC, 8'd3, "ctu_acc3");
    rd(4, K_STAT, 8'h01, "ctu_dn");
    repeat (252) pulse(4, CTU);
    rd(4, K_ACC, 8'd255, "ctu_acc_max");
    rd(4, K_STAT, 8'h01, "ctu_no_ov_yet");
    pulse(4, CTU);
    rd(4, K_ACC, 8'd255, "ctu_sat");
    rd(4, K_STAT, 8'h11, "ctu_ov");
    cfg(4, 1'b1, CTU);
    rd(4, K_STAT, 8'h15, "ctu_cu_ov");
    cfg(4, 1'b0, CTU);

    // rst_we on the same edge as a count event: event dropped.
    cfg(4, 1'b1, CTU);
    rstc(4);
    rd(4, K_ACC, 8'd0, "rst_vs_event_acc");
    rd(4, K_STAT, 8'h04, "rst_vs_event_stat");
    rd(4, K_BOTH, 8'd0, "both_reads_acc");
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid), 32'd0);
    cfg(4, 1'b0, CTU);

    // CTD preset 0 at acc 0: underflow is sticky, acc stays 0.
    setup(5, 8'd0, 1'b0, CTD);
    pulse(5, CTD);
    rd(5, K_ACC, 8'd0, "ctd_acc");
    rd(5, K_STAT, 8'h11, "ctd_un");

    // CTU-wrap preset 2: acc 1,2,0,1 with a single done pulse at the wrap.
    setup(6, 8'd2, 1'b0, CTUW);
    for (int p = 0; p < 4; p++) begin
      pulse(6, CTUW);
      rd(6, K_STAT, wrap_st[p], $sformatf("ctuw_stat%0d", p));
      rd(6, K_ACC, wrap_acc[p], $sformatf("ctuw_acc%0d", p));
    end

    // Unmapped channel 7: writes ignored, reads return zero with rvalid.
    setup(7, 8'd9, 1'b1, CTU);
    rd(7, K_ACC, 8'd0, "bad_ch_acc");
    rd(7, K_STAT, 8'd0, "bad_ch_stat");

    // TOF preset 2: done while enabled, timing after release, then drops.
    setup(2, 8'd2, 1'b1, TOF);
    rd(2, K_STAT, 8'h01, "tof_en_dn");
    cfg(2, 1'b0, TOF);
    rd(2, K_STAT, 8'h03, "tof_timing");
    repeat (16) @(negedge clk);
    rd(2, K_ACC, 8'd2, "tof_acc");
    rd(2, K_STAT, 8'h00, "tof_expired");

    // Asynchronous reset while several channels are active.
    cfg(0, 1'b1, TON);
    cfg(1, 1'b1, RTO);
    cfg(4, 1'b1, CTU);
    cfg(6, 1'b1, CTUW);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      rd(c, K_ACC, 8'd0, $sformatf("post_reset_acc%0d", c));
      rd(c, K_STAT, 8'h00, $sformatf("post_reset_stat%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
